// File: rtl/sft_in_reader_if.sv
// sft_in_reader_if: board-side shift-register pins plus the
// debounced value/strobe bundle seen by the register/TWI side.
interface sft_in_reader_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             sft_q;
    logic             sft_pl_n;
    logic             sft_cp;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             busy;
    logic             irq;
    logic             irq_clr;

    modport master (
        input  en,
        input  sft_q,
        input  irq_clr,
        output sft_pl_n,
        output sft_cp,
        output dout,
        output dout_vld,
        output busy,
        output irq
    );

    modport slave (
        output en,
        output sft_q,
        output irq_clr,
        input  sft_pl_n,
        input  sft_cp,
        input  dout,
        input  dout_vld,
        input  busy,
        input  irq
    );
endinterface

// File: rtl/sft_in_reader.sv
// sft_in_reader: continuous 74HC165-style scanner with scan-to-scan
// debounce. Define SFT_IN_READER_IRQ_EN for the sticky irq flag.
module sft_in_reader #(
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 4,
    parameter int DEBOUNCE = 3,
    parameter int SCAN_GAP = 16
) (
    input logic            clk,
    input logic            rst,
    sft_in_reader_if.master bus
);

    localparam int CMAX = (CLK_DIV > SCAN_GAP) ? CLK_DIV : SCAN_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW   = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(SCAN_GAP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [SW-1:0] DEB_MAX  = SW'(DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        EVAL,
        GAP
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic             phase_q;
    logic [WIDTH-1:0] raw_q;
    logic [WIDTH-1:0] last_raw_q;
    logic [WIDTH-1:0] dout_q;
    logic [SW-1:0]    stable_cnt_q;
    logic [SW-1:0]    stable_cnt_d;
    logic             commit_d;
    logic             sync1_q;
    logic             sync2_q;
    logic             pl_n_q;
    logic             cp_q;
    logic             vld_q;
    logic             busy_q;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.sft_q;
            sync2_q <= sync1_q;
        end
    end

    // Debounce outcome of the scan held in raw_q, used in EVAL.
    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (raw_q == last_raw_q) begin
            if (stable_cnt_q != DEB_MAX) begin
                stable_cnt_d = stable_cnt_q + SW'(1);
            end
        end else begin
            stable_cnt_d = SW'(1);
        end
        commit_d = (stable_cnt_d == DEB_MAX) && (raw_q != dout_q);
    end

    // Scan sequencer with registered pin, value and strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            raw_q        <= '0;
            last_raw_q   <= '0;
            dout_q       <= '0;
            stable_cnt_q <= '0;
            pl_n_q       <= 1'b1;
            cp_q         <= 1'b0;
            vld_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        pl_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt_q == DIV_LAST) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        phase_q <= 1'b0;
                        pl_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        if (!phase_q) begin
                            raw_q   <= {raw_q[WIDTH-2:0], sync2_q};
                            phase_q <= 1'b1;
                            cp_q    <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            cp_q    <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= EVAL;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                EVAL: begin
                    last_raw_q   <= raw_q;
                    stable_cnt_q <= stable_cnt_d;
                    cnt_q        <= '0;
                    if (commit_d) begin
                        dout_q <= raw_q;
                        vld_q  <= 1'b1;
                    end
                    if (bus.en) begin
                        state_q <= GAP;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (bus.en) begin
                            state_q <= LOAD;
                            pl_n_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sft_pl_n = pl_n_q;
    assign bus.sft_cp   = cp_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;
    assign bus.busy     = busy_q;

`ifdef SFT_IN_READER_IRQ_EN
    logic irq_q;

    // Sticky change flag; a new change beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (state_q == EVAL && commit_d) begin
            irq_q <= 1'b1;
        end else if (bus.irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.irq = irq_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = bus.irq_clr;
    assign bus.irq        = 1'b0;
`endif

endmodule
